// File: rtl/packetizer.sv
// ---------------------------------------------------------------------------
// packetizer
//
// Turns load commands into network packets. An ifmap command yields one
// packet carrying the zero-extended ifmap row. A filter command yields three
// packets, one per filter row, tagged with filter_row 1, 2, 3. Every packet
// carries a constant routing header built from the DIRECTION/X_HOP/Y_HOP
// parameters.
//
// Handshake semantics (both ports): a beat transfers on a rising edge where
// valid && ready are both 1. A producer holds valid and its payload stable
// until that edge. ready may be asserted without valid; that has no effect.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous, active-high reset
//   in_valid     : load command presented
//   in_ready     : block can accept a command (IDLE and not in reset)
//   in_kind      : 0 = ifmap, 1 = filter
//   in_timestep  : timestep tag copied into every packet of the command
//   in_data      : 9*FW bits; filter row r at [3*FW*r-1 : 3*FW*(r-1)],
//                  ifmap row at [IFMAP_SIZE-1:0]
//   pkt_valid    : packet presented
//   pkt_ready    : downstream accepts the packet
//   pkt_data     : {DIRECTION, X_HOP, Y_HOP, timestep, ifmapb_filter,
//                   filter_row, data[3*FW-1:0]}
//   dbg_state    : current FSM state (0 = IDLE, 1 = SEND)
//   sent_count   : 16-bit wrapping count of transferred packets, present
//                  only when PACKETIZER_PKT_COUNT_EN is defined
//
// Optional feature macro: PACKETIZER_PKT_COUNT_EN
// ---------------------------------------------------------------------------
module packetizer #(
    parameter int         FILTER_WIDTH = 8,
    parameter int         IFMAP_SIZE   = 9,
    parameter bit         DIRECTION    = 1'b0,
    parameter logic [1:0] X_HOP        = 2'd0,
    parameter logic [1:0] Y_HOP        = 2'd0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_kind,
    input  logic                        in_timestep,
    input  logic [9*FILTER_WIDTH-1:0]   in_data,
    output logic                        pkt_valid,
    input  logic                        pkt_ready,
    output logic [3*FILTER_WIDTH+8:0]   pkt_data,
`ifdef PACKETIZER_PKT_COUNT_EN
    output logic [15:0]                 sent_count,
`endif
    output logic                        dbg_state
);

    localparam int RW = 3 * FILTER_WIDTH;   // width of one filter row / data field
    localparam int PW = RW + 9;             // packet width

    localparam logic [4:0] HDR = {DIRECTION, X_HOP, Y_HOP};

    generate
        if (IFMAP_SIZE > 3 * FILTER_WIDTH) begin : g_bad_cfg
            $error("packetizer: IFMAP_SIZE must not exceed 3*FILTER_WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      row_q, row_d;        // filter_row of the packet on the output
    logic            kind_q, kind_d;      // 1 = filter command in flight
    logic            ts_q, ts_d;
    logic [2*RW-1:0] rows_q, rows_d;      // rows still to send; next row in the low slice
    logic [PW-1:0]   pkt_data_q, pkt_data_d;

    logic accept;
    logic xfer;
    logic last_pkt;

    assign accept   = in_valid && in_ready;
    assign xfer     = pkt_valid && pkt_ready;
    // An ifmap is a single packet; a filter ends after row 3.
    assign last_pkt = !kind_q || (row_q == 2'd3);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)           state_d = SEND;
            SEND: if (xfer && last_pkt) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        pkt_valid = (state_q == SEND);
        // Gated by rst so nothing can be accepted on an edge where reset wins.
        in_ready  = (state_q == IDLE) && !rst;
        dbg_state = state_q;
    end

    // -----------------------------------------------------------------------
    // Datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        row_d      = row_q;
        kind_d     = kind_q;
        ts_d       = ts_q;
        rows_d     = rows_q;
        pkt_data_d = pkt_data_q;

        if (accept) begin
            // Everything needed for the whole command is captured here so
            // later input changes cannot leak into packets in flight.
            ts_d   = in_timestep;
            kind_d = in_kind;
            rows_d = in_data[3*RW-1:RW];
            if (in_kind) begin
                row_d      = 2'd1;
                pkt_data_d = {HDR, in_timestep, 1'b1, 2'd1, in_data[RW-1:0]};
            end else begin
                row_d      = 2'd0;
                pkt_data_d = {HDR, in_timestep, 1'b0, 2'd0,
                              RW'(in_data[IFMAP_SIZE-1:0])};
            end
        end else if (xfer) begin
            if (last_pkt) begin
                row_d = 2'd0;
            end else begin
                // Load the next row on the transfer edge so pkt_valid never
                // drops between filter rows.
                row_d      = row_q + 2'd1;
                pkt_data_d = {HDR, ts_q, 1'b1, row_q + 2'd1, rows_q[RW-1:0]};
                rows_d     = {{RW{1'b0}}, rows_q[2*RW-1:RW]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q      <= 2'd0;
            kind_q     <= 1'b0;
            ts_q       <= 1'b0;
            rows_q     <= '0;
            pkt_data_q <= '0;
        end else begin
            row_q      <= row_d;
            kind_q     <= kind_d;
            ts_q       <= ts_d;
            rows_q     <= rows_d;
            pkt_data_q <= pkt_data_d;
        end
    end

    assign pkt_data = pkt_data_q;

`ifdef PACKETIZER_PKT_COUNT_EN
    // -----------------------------------------------------------------------
    // Transferred-packet counter, wraps naturally at 16 bits
    // -----------------------------------------------------------------------
    logic [15:0] sent_count_q, sent_count_d;

    always_comb begin
        sent_count_d = sent_count_q;
        if (xfer) begin
            sent_count_d = sent_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sent_count_q <= 16'd0;
        end else begin
            sent_count_q <= sent_count_d;
        end
    end

    assign sent_count = sent_count_q;
`endif

endmodule

// File: tb/tb_packetizer.sv
// ---------------------------------------------------------------------------
// tb_packetizer
//
// Randomized bench for packetizer. Accepted commands are expanded into the
// packets they must produce and queued; a monitor on the falling edge pops
// and compares each transferred packet and checks the handshake rules
// (latency, hold under backpressure, back-to-back rows, idle bubble, reset).
// ---------------------------------------------------------------------------
module tb_packetizer;

    localparam int FW  = 8;
    localparam int IFM = 9;
    localparam int RW  = 3 * FW;
    localparam int PW  = RW + 9;
    localparam int DW  = 9 * FW;
    localparam logic [4:0] HDR = 5'b11011;   // DIRECTION=1, X_HOP=2, Y_HOP=3

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_kind;
    logic          in_timestep;
    logic [DW-1:0] in_data;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [PW-1:0] pkt_data;
    logic          dbg_state;
`ifdef PACKETIZER_PKT_COUNT_EN
    logic [15:0]   sent_count;
`endif

    packetizer #(
        .FILTER_WIDTH (FW),
        .IFMAP_SIZE   (IFM),
        .DIRECTION    (1'b1),
        .X_HOP        (2'd2),
        .Y_HOP        (2'd3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .in_timestep (in_timestep),
        .in_data     (in_data),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_data    (pkt_data),
`ifdef PACKETIZER_PKT_COUNT_EN
        .sent_count  (sent_count),
`endif
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset bookkeeping ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_at_edge = 1'b0;
    always @(posedge clk) rst_at_edge = rst;

    // ---------------- scoreboard state ----------------
    logic [PW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [15:0]   exp_cnt = 16'd0;
    logic          cnt_chk_en = 1'b1;
    logic          ready_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what a command must produce, straight from the
    // packet format rules.
    task automatic push_expected(input logic kind, input logic ts, input logic [DW-1:0] data);
        logic [RW-1:0] payload;
        if (!kind) begin
            payload = '0;
            for (int b = 0; b < IFM; b++) payload[b] = data[b];
            exp_q.push_back({HDR, ts, 1'b0, 2'd0, payload});
        end else begin
            for (int r = 1; r <= 3; r++) begin
                payload = data[RW*r-1 -: RW];
                exp_q.push_back({HDR, ts, 1'b1, 2'(r), payload});
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic          want_valid = 1'b0;
    logic          want_idle  = 1'b0;
    logic          hold_chk   = 1'b0;
    logic [PW-1:0] held_data  = '0;

    always @(negedge clk) begin
        logic [PW-1:0] exp;
        if (rst) begin
            exp_q.delete();
            want_valid = 1'b0;
            want_idle  = 1'b0;
            hold_chk   = 1'b0;
            check("in_ready_in_reset", in_ready, 1'b0);
            if (rst_at_edge) begin
                exp_cnt = 16'd0;
                check("pkt_valid_in_reset", pkt_valid, 1'b0);
                check("pkt_data_in_reset", pkt_data, 0);
            end
        end else begin
`ifdef PACKETIZER_PKT_COUNT_EN
            if (cnt_chk_en) check("sent_count", sent_count, exp_cnt);
`endif
            if (rst_at_edge) check("in_ready_after_reset", in_ready, 1'b1);
            if (want_valid)  check("pkt_valid_expected", pkt_valid, 1'b1);
            if (want_idle) begin
                check("idle_bubble_valid", pkt_valid, 1'b0);
                check("idle_bubble_in_ready", in_ready, 1'b1);
            end
            if (hold_chk) begin
                check("hold_valid", pkt_valid, 1'b1);
                check("hold_data", pkt_data, held_data);
            end
            if (pkt_valid) begin
                check("in_ready_busy", in_ready, 1'b0);
                check("header", pkt_data[PW-1 -: 5], HDR);
            end

            want_valid = 1'b0;
            want_idle  = 1'b0;
            hold_chk   = 1'b0;

            if (in_valid && in_ready) begin
                push_expected(in_kind, in_timestep, in_data);
                want_valid = 1'b1;
            end
            if (pkt_valid) begin
                if (pkt_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_packet", pkt_valid, 1'b0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("pkt_data", pkt_data, exp);
                        exp_cnt = exp_cnt + 16'd1;
                        if (exp_q.size() != 0) want_valid = 1'b1;
                        else                   want_idle  = 1'b1;
                    end
                end else begin
                    hold_chk  = 1'b1;
                    held_data = pkt_data;
                end
            end
        end
    end

    // ---------------- random backpressure ----------------
    always @(posedge clk) begin
        #1;
        if (ready_rand) pkt_ready = ($urandom_range(0, 9) < 7);
    end

    // ---------------- driver tasks ----------------
    function automatic logic [DW-1:0] rand_data();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // Called one step after a rising edge; returns one step after the
    // acceptance edge with the inputs scrambled.
    task automatic send_cmd(input logic kind, input logic ts, input logic [DW-1:0] data);
        int n;
        n = 0;
        in_valid    = 1'b1;
        in_kind     = kind;
        in_timestep = ts;
        in_data     = data;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_kind     = 1'($urandom);
        in_timestep = 1'($urandom);
        in_data     = rand_data();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pkt_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_kind     = 1'b0;
        in_timestep = 1'b0;
        in_data     = '0;
        pkt_ready   = 1'b1;

        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(1);

        // Ifmap with junk above the ifmap bits: expect data 24'h0001A5.
        d = rand_data();
        d[8:0] = 9'h1A5;
        send_cmd(1'b0, 1'b1, d);
        wait_drain();

        // Filter, ready tied high: three back-to-back rows.
        send_cmd(1'b1, 1'b0, {24'h090807, 24'h060504, 24'h030201});
        wait_drain();

        // Backpressure for 5 cycles on row 2.
        send_cmd(1'b1, 1'b1, rand_data());
        @(posedge clk);
        #1;
        pkt_ready = 1'b0;
        idle_cycles(5);
        pkt_ready = 1'b1;
        wait_drain();

`ifdef PACKETIZER_PKT_COUNT_EN
        check("sent_count_after_7", sent_count, 16'd7);
`endif

        // Reset right after row 1 transfers; rows 2 and 3 must never appear.
        send_cmd(1'b1, 1'b0, rand_data());
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(8);

        // Stray ready pulses while idle must do nothing.
        pkt_ready = 1'b0;
        idle_cycles(1);
        pkt_ready = 1'b1;
        idle_cycles(3);

        // Randomized commands with random backpressure and gaps.
        ready_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            idle_cycles($urandom_range(0, 3));
            send_cmd(1'($urandom), 1'($urandom), rand_data());
        end
        ready_rand = 1'b0;
        idle_cycles(1);
        pkt_ready = 1'b1;
        wait_drain();

`ifdef PACKETIZER_PKT_COUNT_EN
        // Wrap from 65535 to 0.
        cnt_chk_en = 1'b0;
        force dut.sent_count_q = 16'hFFFF;
        idle_cycles(1);
        release dut.sent_count_q;
        exp_cnt    = 16'hFFFF;
        cnt_chk_en = 1'b1;
        send_cmd(1'b0, 1'b0, rand_data());
        wait_drain();
        check("sent_count_wrap", sent_count, 16'd0);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
